mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Sequences every access to the byte-wide unified RAM, one byte per cycle.
- Arbitrates between two requesters: instruction fetch (always 4 bytes) and the load/store stage, which issues the 5-bit mem-enable code produced by ex.
- Assembles load data and applies sign or zero extension; splits store data into bytes.
- Sits between IF/MEM and the RAM port; it is the only master of that port.

Parameters:
- ADDR_W, 17, RAM byte-address width; all RAM addresses wrap modulo 2^ADDR_W.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset; rst==0 sampled at a rising edge resets the block.
- flush  in  1  abort the fetch in progress (pc redirect).
- if_req  in  1  fetch request; level signal, held until if_ack.
- if_addr  in  32  fetch byte address.
- if_ack  out  1  one-cycle pulse; if_data valid in the same cycle.
- if_data  out  32  fetched word, little-endian.
- mem_e  in  5  [4]=enable/request, [3:2]=len (byte count−1: 0=byte, 1=half, 3=word), [1]=write, [0]=unsigned load. Held until mem_ack.
- mem_addr  in  32  data byte address.
- mem_wdata  in  32  store data; low len+1 bytes are used.
- mem_ack  out  1  one-cycle completion pulse; mem_rdata valid in the same cycle for loads.
- mem_rdata  out  32  extended load data.
- ram_a  out  ADDR_W  RAM byte address.
- ram_wr  out  1  RAM write strobe.
- ram_dout  out  8  RAM write byte.
- ram_din  in  8  RAM read byte; valid one cycle after its address is driven.

Behaviour:
- States: IDLE, BUSY, ACK. Internal registers: cnt[2:0], base address, n = len+1, wr, uns, grant (0=fetch, 1=data), last_grant, buf[31:0].
- Reset (rst==0 at an edge):
  - state←IDLE, cnt←0, last_grant←1 (data), buf←0.
  - Outputs: if_ack=0, mem_ack=0, ram_wr=0, ram_a=0, ram_dout=0, if_data=0, mem_rdata=0.
  - An access in flight is dropped silently: no ack, and no further RAM writes after the reset edge.
- IDLE: if any request is pending, latch its fields, set grant, go to BUSY with cnt←0.
  - Only one pending: that requester wins.
  - Both pending: the requester opposite to last_grant wins. last_grant←grant at every grant.
  - A fetch is always n=4, wr=0.
  - A request whose mem_e[4]=0 is not a request.
- BUSY:
  - ram_a = (base+cnt) mod 2^ADDR_W while cnt<n.
  - Write: ram_wr=1, ram_dout=wdata byte cnt. cnt runs 0..n−1; at cnt==n−1 go to ACK. A write takes n BUSY cycles.
  - Read: ram_wr=0. When cnt≥1, buf byte (cnt−1)←ram_din. cnt runs 0..n; at cnt==n go to ACK. A read takes n+1 BUSY cycles.
  - ram_a in the cnt==n cycle is don't-care; ram_wr=0 there.
- ACK: assert the granted ack for exactly one cycle, then go to IDLE. The requester drops or changes its request on the edge ending ACK; IDLE samples fresh requests on the next edge.
- Latency, counting BUSY entry as edge 0:
  - Word read: ack in the 6th cycle after the grant edge.
  - Byte read: ack in the 3rd cycle.
  - Word write: ack in the 5th cycle.
- Load extension on mem_rdata:
  - n=1: uns ? zero-extend : sign-extend from bit 7.
  - n=2: same rule from bit 15.
  - n=3: zero-extend.
  - n=4: raw.
  - if_data is raw buf.
- mem_rdata and if_data hold their last value outside the ack cycle.
- Flush:
  - While grant=fetch in BUSY or ACK, flush forces IDLE on that edge.
  - The if_ack for that fetch is suppressed, including in the ACK cycle itself; flush is combinationally masked onto if_ack.
  - Flush has no effect on data transactions or in IDLE.
- Address wrap: base+cnt carries past 2^ADDR_W−1 back to 0. Misaligned accesses are legal.

Decomposition:
- Package mem_ctrl_pkg: state enum; mem_e field indices (E_EN=4, E_LEN_HI=3, E_LEN_LO=2, E_WR=1, E_UNS=0); LEN_BYTE=0, LEN_HALF=1, LEN_WORD=3.
- Sub-module mem_arb: 2-way round-robin grant from (if_req, mem_e[4], last_grant).

Test Plan:
- Word fetch: after reset, if_req at 0x100 with RAM bytes 13,05,00,00 → ram_a 0x100..0x103 on consecutive cycles, if_ack pulse 6 cycles after grant, if_data=0x00000513.
- Extension: RAM[0x10]=0x80, RAM[0x11]=0x80 →
  - LB at 0x10: mem_rdata=0xFFFFFF80.
  - LBU at 0x10: mem_rdata=0x00000080.
  - LH at 0x11 with RAM[0x12]=0x01: mem_rdata=0x00000180.
  - LHU with bytes 01,80: mem_rdata=0x00008001.
- Word store: SW 0xDEADBEEF at 0x20 → ram_wr high 4 cycles, bytes EF,BE,AD,DE at 0x20..0x23, mem_ack in the 5th cycle, no if_ack.
- Arbitration: if_req and a load asserted in the same cycle after reset → fetch granted first, load granted on the first IDLE after; under continuous contention grants alternate F,D,F,D.
- Flush: assert flush in BUSY cnt=2 of a fetch while a load is pending → no if_ack, IDLE next cycle, load granted on the following edge and completes normally.
- Reset and wrap: rst=0 during cnt=1 of SW → ram_wr=0 from the next cycle, no mem_ack. Word read at 0x1FFFF → ram_a 0x1FFFF,0x00000,0x00001,0x00002.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state codes, mem_e field layout and load-extension helper.
package mem_ctrl_pkg;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_ACK  = 2'd2;
   localparam int E_EN     = 4;
   localparam int E_LEN_HI = 3;
   localparam int E_LEN_LO = 2;
   localparam int E_WR     = 1;
   localparam int E_UNS    = 0;
   localparam logic [1:0] LEN_BYTE = 2'd0;
   localparam logic [1:0] LEN_HALF = 2'd1;
   localparam logic [1:0] LEN_WORD = 2'd3;
   function automatic logic [31:0] ext(input logic [31:0] b, input logic [1:0] len, input logic uns);
      return len == LEN_BYTE ? {{24{b[7] & ~uns}}, b[7:0]} :
             len == LEN_HALF ? {{16{b[15] & ~uns}}, b[15:0]} :
             len == LEN_WORD ? b : {8'h00, b[23:0]};
   endfunction
endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: requester (fetch, load/store) and byte-RAM port signals of mem_ctrl.
interface mem_ctrl_if #(
   parameter int ADDR_W = 17
);
   logic              flush, if_req, if_ack, mem_ack, ram_wr;
   logic [31:0]       if_addr, if_data, mem_addr, mem_wdata, mem_rdata;
   logic [4:0]        mem_e;
   logic [ADDR_W-1:0] ram_a;
   logic [7:0]        ram_dout, ram_din;
   modport slave (
      input  flush, if_req, if_addr, mem_e, mem_addr, mem_wdata, ram_din,
      output if_ack, if_data, mem_ack, mem_rdata, ram_a, ram_wr, ram_dout
   );
   modport master (
      output flush, if_req, if_addr, mem_e, mem_addr, mem_wdata, ram_din,
      input  if_ack, if_data, mem_ack, mem_rdata, ram_a, ram_wr, ram_dout
   );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: two-way round-robin grant between fetch (0) and data (1).
module mem_arb (
   input  logic if_req_i,
   input  logic d_req_i,
   input  logic last_i,
   output logic valid_o,
   output logic grant_o
);
   assign valid_o = if_req_i | d_req_i;
   assign grant_o = (if_req_i & d_req_i) ? ~last_i : d_req_i;
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: sequences fetch and load/store accesses onto a byte-wide RAM, one byte per cycle.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 17
) (
   input logic       clk,
   input logic       rst,
   mem_ctrl_if.slave bus
);
   logic [1:0]        state_q, state_d, len_q, len_d;
   logic [2:0]        cnt_q, cnt_d, cm1;
   logic [ADDR_W-1:0] base_q, base_d;
   logic              wr_q, wr_d, uns_q, uns_d, gnt_q, gnt_d, last_q, last_d;
   logic [31:0]       wdata_q, wdata_d, buf_q, buf_d, ifd_q, rdd_q;
   logic              arb_v, arb_g, busy, done;
   logic              unused_addr;
   assign unused_addr = ^{bus.if_addr[31:ADDR_W], bus.mem_addr[31:ADDR_W]};
   mem_arb u_arb (
      .if_req_i(bus.if_req),
      .d_req_i (bus.mem_e[E_EN]),
      .last_i  (last_q),
      .valid_o (arb_v),
      .grant_o (arb_g)
   );
   assign busy = state_q == S_BUSY;
   assign cm1  = cnt_q - 3'd1;
   // reads need one extra cycle for the last byte to return from the RAM
   assign done = wr_q ? cnt_q == {1'b0, len_q} : cnt_q == {1'b0, len_q} + 3'd1;
   assign bus.ram_a     = busy ? base_q + ADDR_W'(cnt_q) : '0;
   assign bus.ram_wr    = busy & wr_q;
   assign bus.ram_dout  = bus.ram_wr ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
   assign bus.if_ack    = state_q == S_ACK & ~gnt_q & ~bus.flush;
   assign bus.mem_ack   = state_q == S_ACK & gnt_q;
   assign bus.if_data   = bus.if_ack ? buf_q : ifd_q;
   assign bus.mem_rdata = bus.mem_ack ? ext(buf_q, len_q, uns_q) : rdd_q;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      len_d   = len_q;
      wr_d    = wr_q;
      uns_d   = uns_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      wdata_d = wdata_q;
      buf_d   = buf_q;
      case (state_q)
         S_IDLE: if (arb_v) begin
            state_d = S_BUSY;
            cnt_d   = 3'd0;
            gnt_d   = arb_g;
            last_d  = arb_g;
            base_d  = arb_g ? bus.mem_addr[ADDR_W-1:0] : bus.if_addr[ADDR_W-1:0];
            len_d   = arb_g ? bus.mem_e[E_LEN_HI:E_LEN_LO] : LEN_WORD;
            wr_d    = arb_g & bus.mem_e[E_WR];
            uns_d   = bus.mem_e[E_UNS];
            wdata_d = bus.mem_wdata;
         end
         S_BUSY: begin
            if (!wr_q && cnt_q != 3'd0) buf_d[{cm1[1:0], 3'b000} +: 8] = bus.ram_din;
            cnt_d   = cnt_q + 3'd1;
            state_d = done ? S_ACK : S_BUSY;
         end
         default: state_d = S_IDLE;
      endcase
      // a pc redirect abandons the fetch, even in its ack cycle
      if (bus.flush && !gnt_q && state_q != S_IDLE) state_d = S_IDLE;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         base_q  <= '0;
         len_q   <= '0;
         wr_q    <= 1'b0;
         uns_q   <= 1'b0;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         wdata_q <= '0;
         buf_q   <= '0;
         ifd_q   <= '0;
         rdd_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         len_q   <= len_d;
         wr_q    <= wr_d;
         uns_q   <= uns_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         wdata_q <= wdata_d;
         buf_q   <= buf_d;
         ifd_q   <= bus.if_data;
         rdd_q   <= bus.mem_rdata;
      end
   end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl against a byte RAM model with hand-computed expectations.
module tb_mem_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [7:0] mem [0:131071];
   mem_ctrl_if #(.ADDR_W(17)) bus ();
   mem_ctrl #(.ADDR_W(17)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (bus.ram_wr) mem[bus.ram_a] <= bus.ram_dout;
      bus.ram_din <= mem[bus.ram_a];
   end
   task automatic tick();
      @(negedge clk);
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic wait_ack(input bit d, output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!(d ? bus.mem_ack : bus.if_ack) && cyc < 20);
   endtask
   task automatic load(input string tag, input logic [31:0] a, input logic [1:0] len,
                       input logic u, input logic [31:0] exp, input int lat);
      int cyc;
      bus.mem_addr = a;
      bus.mem_e    = {1'b1, len, 1'b0, u};
      wait_ack(1'b1, cyc);
      chk({tag, " latency"}, 32'(cyc), 32'(lat));
      chk(tag, bus.mem_rdata, exp);
      bus.mem_e = '0;
      tick();
   endtask
   initial begin
      int cyc, acks;
      logic [3:0] seq;
      logic [31:0] w;
      logic [16:0] wa [4];
      bus.flush = 0; bus.if_req = 0; bus.if_addr = 0;
      bus.mem_e = 0; bus.mem_addr = 0; bus.mem_wdata = 0;
      mem[17'h100] = 8'h13; mem[17'h101] = 8'h05; mem[17'h102] = 8'h00; mem[17'h103] = 8'h00;
      mem[17'h10] = 8'h80; mem[17'h11] = 8'h80; mem[17'h12] = 8'h01; mem[17'h13] = 8'h80;
      mem[17'h40] = 8'h00; mem[17'h41] = 8'h00; mem[17'h42] = 8'h00; mem[17'h43] = 8'h00;
      mem[17'h1FFFF] = 8'h11; mem[17'h0] = 8'h22; mem[17'h1] = 8'h33; mem[17'h2] = 8'h44;
      tick(); tick();
      chk("rst if_ack", 32'(bus.if_ack), 32'd0);
      chk("rst mem_ack", 32'(bus.mem_ack), 32'd0);
      chk("rst ram_wr", 32'(bus.ram_wr), 32'd0);
      chk("rst ram_a", 32'(bus.ram_a), 32'd0);
      chk("rst ram_dout", 32'(bus.ram_dout), 32'd0);
      chk("rst if_data", bus.if_data, 32'd0);
      chk("rst mem_rdata", bus.mem_rdata, 32'd0);
      rst = 1'b1;
      // word fetch at 0x100
      bus.if_addr = 32'h100; bus.if_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("fetch ram_a", 32'(bus.ram_a), 32'h100 + 32'(k));
      end
      tick();
      chk("fetch early ack", 32'(bus.if_ack), 32'd0);
      tick();
      chk("fetch if_ack", 32'(bus.if_ack), 32'd1);
      chk("fetch if_data", bus.if_data, 32'h00000513);
      chk("fetch mem_ack", 32'(bus.mem_ack), 32'd0);
      bus.if_req = 1'b0;
      tick(); tick();
      chk("fetch hold if_data", bus.if_data, 32'h00000513);
      // load extension
      load("lb", 32'h10, 2'd0, 1'b0, 32'hFFFFFF80, 3);
      load("lbu", 32'h10, 2'd0, 1'b1, 32'h00000080, 3);
      load("lh", 32'h11, 2'd1, 1'b0, 32'h00000180, 4);
      load("lhu", 32'h12, 2'd1, 1'b1, 32'h00008001, 4);
      load("lh neg", 32'h12, 2'd1, 1'b0, 32'hFFFF8001, 4);
      load("l3", 32'h10, 2'd2, 1'b0, 32'h00018080, 5);
      load("lw", 32'h10, 2'd3, 1'b0, 32'h80018080, 6);
      chk("hold mem_rdata", bus.mem_rdata, 32'h80018080);
      // word store
      w = 32'hDEADBEEF;
      bus.mem_addr = 32'h20; bus.mem_wdata = w; bus.mem_e = 5'b1_11_1_0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("sw ram_wr", 32'(bus.ram_wr), 32'd1);
         chk("sw ram_a", 32'(bus.ram_a), 32'h20 + 32'(k));
         chk("sw ram_dout", 32'(bus.ram_dout), 32'(w[8*k +: 8]));
      end
      tick();
      chk("sw mem_ack", 32'(bus.mem_ack), 32'd1);
      chk("sw if_ack", 32'(bus.if_ack), 32'd0);
      chk("sw ram_wr off", 32'(bus.ram_wr), 32'd0);
      bus.mem_e = '0;
      tick();
      load("lw back", 32'h20, 2'd3, 1'b0, 32'hDEADBEEF, 6);
      // arbitration after reset: fetch first, then the load
      rst = 1'b0; tick(); rst = 1'b1;
      bus.if_addr = 32'h100; bus.if_req = 1'b1;
      bus.mem_addr = 32'h10; bus.mem_e = 5'b1_00_0_0;
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!(bus.if_ack || bus.mem_ack) && cyc < 20);
      chk("arb first if_ack", 32'(bus.if_ack), 32'd1);
      chk("arb first mem_ack", 32'(bus.mem_ack), 32'd0);
      chk("arb first latency", 32'(cyc), 32'd6);
      chk("arb first if_data", bus.if_data, 32'h00000513);
      bus.if_req = 1'b0;
      wait_ack(1'b1, cyc);
      chk("arb second latency", 32'(cyc), 32'd4);
      chk("arb second rdata", bus.mem_rdata, 32'hFFFFFF80);
      // continuous contention alternates F,D,F,D
      bus.if_req = 1'b1;
      seq = '0; acks = 0;
      for (int i = 0; i < 80 && acks < 4; i++) begin
         tick();
         if (bus.if_ack || bus.mem_ack) begin
            seq = {seq[2:0], bus.mem_ack};
            acks++;
         end
      end
      chk("rr ack count", 32'(acks), 32'd4);
      chk("rr order", 32'(seq), 32'b0101);
      bus.if_req = 1'b0; bus.mem_e = '0;
      tick(); tick();
      // flush mid-fetch with a load pending
      bus.if_addr = 32'h100; bus.if_req = 1'b1;
      bus.mem_addr = 32'h10; bus.mem_e = 5'b1_00_0_1;
      tick(); tick(); tick();
      chk("flush cnt2 ram_a", 32'(bus.ram_a), 32'h102);
      bus.flush = 1'b1; bus.if_req = 1'b0;
      tick();
      bus.flush = 1'b0;
      chk("flush no if_ack", 32'(bus.if_ack), 32'd0);
      chk("flush idle ram_a", 32'(bus.ram_a), 32'd0);
      tick();
      chk("flush load granted", 32'(bus.ram_a), 32'h10);
      wait_ack(1'b1, cyc);
      chk("flush load latency", 32'(cyc), 32'd2);
      chk("flush load rdata", bus.mem_rdata, 32'h00000080);
      bus.mem_e = '0;
      tick();
      // flush in the ack cycle masks if_ack combinationally
      bus.if_addr = 32'h10; bus.if_req = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      chk("ack-flush pre", 32'(bus.if_ack), 32'd1);
      bus.flush = 1'b1;
      #1;
      chk("ack-flush if_ack", 32'(bus.if_ack), 32'd0);
      chk("ack-flush if_data", bus.if_data, 32'h00000513);
      bus.if_req = 1'b0;
      tick();
      bus.flush = 1'b0;
      chk("ack-flush after", 32'(bus.if_ack), 32'd0);
      // reset during a store
      bus.mem_addr = 32'h40; bus.mem_wdata = 32'h11223344; bus.mem_e = 5'b1_11_1_0;
      tick();
      chk("rst-sw cnt0 wr", 32'(bus.ram_wr), 32'd1);
      tick();
      chk("rst-sw cnt1 ram_a", 32'(bus.ram_a), 32'h41);
      rst = 1'b0; bus.mem_e = '0;
      tick();
      chk("rst-sw ram_wr", 32'(bus.ram_wr), 32'd0);
      chk("rst-sw ram_a", 32'(bus.ram_a), 32'd0);
      rst = 1'b1;
      acks = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (bus.mem_ack || bus.ram_wr) acks++;
      end
      chk("rst-sw no ack/wr", 32'(acks), 32'd0);
      chk("rst-sw mem40", 32'(mem[17'h40]), 32'h44);
      chk("rst-sw mem41", 32'(mem[17'h41]), 32'h33);
      chk("rst-sw mem42", 32'(mem[17'h42]), 32'h00);
      chk("rst-sw mem43", 32'(mem[17'h43]), 32'h00);
      // address wrap
      wa = '{17'h1FFFF, 17'h00000, 17'h00001, 17'h00002};
      bus.mem_addr = 32'h0001FFFF; bus.mem_e = 5'b1_11_0_0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("wrap ram_a", 32'(bus.ram_a), 32'(wa[k]));
      end
      wait_ack(1'b1, cyc);
      chk("wrap latency", 32'(cyc), 32'd2);
      chk("wrap rdata", bus.mem_rdata, 32'h44332211);
      bus.mem_e = '0;
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
